trade_signal: RTL and testbench

- Downstream consumer of the ITCH parser's decoded-field outputs.
- Keeps a sliding window of the last 2^WIN_LOG2 trade ('T', 0x54) prices and a running sum of that window.
- Compares each new trade price against the window mean and emits a mean-reversion order: buy when the price is below the mean, sell when it is above.
- Orders leave on a valid/ready interface toward the order-entry stage.

---
 rtl/trade_signal.sv | 157 +++++++++++++++
 tb/tb_trade_signal.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trade_signal.sv
// ---------------------------------------------------------------------------
// trade_signal : sliding-window mean-reversion order generator on ITCH trades
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trade_signal #(
  parameter int          WIN_LOG2 = 3,
  parameter logic [31:0] THRESH   = 32'd5,
  parameter logic [31:0] QTY_MAX  = 32'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  msg_type,
  input  logic        field_valid,
  input  logic [63:0] order_id,
  input  logic [31:0] price,
  input  logic [31:0] volume,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_side,
  output logic [31:0] out_price,
  output logic [31:0] out_qty,
  output logic [63:0] out_ref_id,
  output logic        warm,
  output logic [15:0] drop_count
);

  localparam int                DEPTH     = 1 << WIN_LOG2;
  localparam int                SW        = 32 + WIN_LOG2;
  localparam logic [WIN_LOG2:0] FILL_FULL = (WIN_LOG2 + 1)'(DEPTH);
  localparam logic [WIN_LOG2:0] FILL_ONE  = (WIN_LOG2 + 1)'(1);
  localparam logic [WIN_LOG2-1:0] PTR_ONE = WIN_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DECIDE = 2'd2,
    EMIT   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         ring_q [DEPTH];
  logic [SW-1:0]       sum_q;
  logic [WIN_LOG2:0]   fill_q;
  logic [WIN_LOG2-1:0] wr_ptr_q;
  logic [31:0]         price_q;
  logic [31:0]         vol_q;
  logic [63:0]         id_q;
  logic                out_valid_q;
  logic                out_side_q;
  logic [31:0]         out_price_q;
  logic [31:0]         out_qty_q;
  logic [63:0]         out_ref_q;
  logic                warm_q;
  logic [15:0]         drop_q;

  logic                trade_evt;
  logic                full;
  logic [31:0]         avg;
  logic [32:0]         price_ext;
  logic [32:0]         avg_ext;
  logic                buy;
  logic                sell;
  logic [WIN_LOG2:0]   fill_inc;

  assign trade_evt = field_valid && (msg_type == 8'h54);
  assign full      = (fill_q == FILL_FULL);
  // Sum already includes the newest price by the time DECIDE reads it.
  assign avg       = sum_q[SW-1:WIN_LOG2];
  assign price_ext = {1'b0, price_q};
  assign avg_ext   = {1'b0, avg};
  assign buy       = (price_ext + {1'b0, THRESH}) < avg_ext;
  assign sell      = price_ext > (avg_ext + {1'b0, THRESH});
  assign fill_inc  = full ? FILL_FULL : (fill_q + FILL_ONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trade_evt) state_d = UPDATE;
      UPDATE:  state_d = DECIDE;
      DECIDE:  state_d = (full && (buy || sell)) ? EMIT : IDLE;
      EMIT:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      wr_ptr_q    <= '0;
      price_q     <= '0;
      vol_q       <= '0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      out_side_q  <= 1'b0;
      out_price_q <= '0;
      out_qty_q   <= '0;
      out_ref_q   <= '0;
      warm_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      if (trade_evt && (state_q != IDLE) && (drop_q != 16'hFFFF))
        drop_q <= drop_q + 16'd1;

      case (state_q)
        IDLE: begin
          if (trade_evt) begin
            price_q <= price;
            vol_q   <= volume;
            id_q    <= order_id;
          end
        end
        UPDATE: begin
          // The outgoing slot value is part of sum_q, so this never underflows.
          sum_q <= sum_q - {{WIN_LOG2{1'b0}}, ring_q[wr_ptr_q]}
                         + {{WIN_LOG2{1'b0}}, price_q};
          ring_q[wr_ptr_q] <= price_q;
          wr_ptr_q         <= wr_ptr_q + PTR_ONE;
          fill_q           <= fill_inc;
          warm_q           <= (fill_inc == FILL_FULL);
        end
        DECIDE: begin
          if (full && (buy || sell)) begin
            out_valid_q <= 1'b1;
            out_side_q  <= buy;
            out_price_q <= price_q;
            out_qty_q   <= (vol_q > QTY_MAX) ? QTY_MAX : vol_q;
            out_ref_q   <= id_q;
          end
        end
        EMIT: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_side   = out_side_q;
  assign out_price  = out_price_q;
  assign out_qty    = out_qty_q;
  assign out_ref_id = out_ref_q;
  assign warm       = warm_q;
  assign drop_count = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_trade_signal.sv
// ---------------------------------------------------------------------------
// tb_trade_signal : scenario tasks plus random trades against a window model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_trade_signal;

  localparam int          DEPTH   = 8;
  localparam logic [31:0] THRESH  = 32'd5;
  localparam logic [31:0] QTY_MAX = 32'd1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  msg_type = 8'h00;
  logic        field_valid = 1'b0;
  logic [63:0] order_id = '0;
  logic [31:0] price = '0;
  logic [31:0] volume = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_side;
  logic [31:0] out_price;
  logic [31:0] out_qty;
  logic [63:0] out_ref_id;
  logic        warm;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] win_q[$];
  int exp_drops = 0;

  trade_signal #(.WIN_LOG2(3), .THRESH(THRESH), .QTY_MAX(QTY_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .msg_type(msg_type), .field_valid(field_valid),
    .order_id(order_id), .price(price), .volume(volume), .out_valid(out_valid),
    .out_ready(out_ready), .out_side(out_side), .out_price(out_price),
    .out_qty(out_qty), .out_ref_id(out_ref_id), .warm(warm), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference: mean of the last DEPTH accepted trade prices.
  function automatic void model_step(input logic [31:0] p, input logic [31:0] v,
                                     output logic ev, output logic es, output logic [31:0] eq);
    longint unsigned s, mean;
    win_q.push_back(p);
    if (win_q.size() > DEPTH) void'(win_q.pop_front());
    ev = 1'b0;
    es = 1'b0;
    eq = (v > QTY_MAX) ? QTY_MAX : v;
    if (win_q.size() == DEPTH) begin
      s = 0;
      foreach (win_q[i]) s += longint'(win_q[i]);
      mean = s / DEPTH;
      if (longint'(p) + longint'(THRESH) < mean) begin
        ev = 1'b1; es = 1'b1;
      end else if (longint'(p) > mean + longint'(THRESH)) begin
        ev = 1'b1; es = 1'b0;
      end
    end
  endfunction

  task automatic fire(input logic [7:0] mt, input logic [31:0] p, input logic [31:0] v,
                      input logic [63:0] id);
    @(negedge clk);
    msg_type = mt; price = p; volume = v; order_id = id; field_valid = 1'b1;
    @(negedge clk);
    field_valid = 1'b0;
  endtask

  // Sends one trade with out_ready high; captures out_valid after E1 and E2.
  task automatic trade(input logic [31:0] p, input logic [31:0] v, input logic [63:0] id,
                       output logic pv, output logic gv, output logic gs,
                       output logic [31:0] gp, output logic [31:0] gq, output logic [63:0] gr);
    fire(8'h54, p, v, id);
    @(negedge clk);
    pv = out_valid;
    @(negedge clk);
    gv = out_valid; gs = out_side; gp = out_price; gq = out_qty; gr = out_ref_id;
    if (gv) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", out_valid); end
    checks++; if (warm !== 1'b0) begin errors++; $display("FAIL reset_warm got %0h exp 0", warm); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0h exp 0", drop_count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_warmup();
    logic pv, gv, gs, ev, es;
    logic [31:0] gp, gq, eq;
    logic [63:0] gr;
    for (int i = 0; i < 7; i++) begin
      model_step(32'd100, 32'd1, ev, es, eq);
      trade(32'd100, 32'd1, 64'(i), pv, gv, gs, gp, gq, gr);
      checks++; if (pv !== 1'b0 || gv !== ev) begin errors++; $display("FAIL warmup_valid[%0d] got %0h exp %0h", i, gv, ev); end
    end
    checks++; if (warm !== 1'b0) begin errors++; $display("FAIL warmup_cold got %0h exp 0", warm); end
    model_step(32'd100, 32'd1, ev, es, eq);
    trade(32'd100, 32'd1, 64'd7, pv, gv, gs, gp, gq, gr);
    checks++; if (gv !== ev) begin errors++; $display("FAIL warmup_8th_valid got %0h exp %0h", gv, ev); end
    checks++; if (warm !== 1'b1) begin errors++; $display("FAIL warmup_warm got %0h exp 1", warm); end
  endtask

  task automatic test_buy();
    logic pv, gv, gs, ev, es;
    logic [31:0] gp, gq, eq;
    logic [63:0] gr;
    model_step(32'd60, 32'd10, ev, es, eq);
    trade(32'd60, 32'd10, 64'hAB, pv, gv, gs, gp, gq, gr);
    checks++; if (pv !== 1'b0) begin errors++; $display("FAIL buy_early got %0h exp 0", pv); end
    checks++; if (gv !== 1'b1 || ev !== 1'b1) begin errors++; $display("FAIL buy_valid got %0h exp 1 (model %0h)", gv, ev); end
    checks++; if (gs !== 1'b1) begin errors++; $display("FAIL buy_side got %0h exp 1", gs); end
    checks++; if (gp !== 32'd60) begin errors++; $display("FAIL buy_price got %0d exp 60", gp); end
    checks++; if (gq !== eq) begin errors++; $display("FAIL buy_qty got %0d exp %0d", gq, eq); end
    checks++; if (gr !== 64'hAB) begin errors++; $display("FAIL buy_ref got %0h exp ab", gr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL buy_handshake got %0h exp 0", out_valid); end
  endtask

  task automatic test_sell_wrap();
    logic pv, gv, gs, ev, es;
    logic [31:0] gp, gq, eq;
    logic [63:0] gr;
    for (int i = 0; i < DEPTH; i++) begin
      model_step(32'd100, 32'd3, ev, es, eq);
      trade(32'd100, 32'd3, 64'(100 + i), pv, gv, gs, gp, gq, gr);
      checks++; if (gv !== ev) begin errors++; $display("FAIL refill_valid[%0d] got %0h exp %0h", i, gv, ev); end
    end
    model_step(32'd200, 32'd7, ev, es, eq);
    trade(32'd200, 32'd7, 64'h5E11, pv, gv, gs, gp, gq, gr);
    checks++; if (gv !== 1'b1 || ev !== 1'b1) begin errors++; $display("FAIL sell_valid got %0h exp 1", gv); end
    checks++; if (gs !== 1'b0) begin errors++; $display("FAIL sell_side got %0h exp 0", gs); end
    checks++; if (gp !== 32'd200) begin errors++; $display("FAIL sell_price got %0d exp 200", gp); end
    // Window sum 900 -> mean 112, so a trade at 100 is a buy.
    model_step(32'd100, 32'd4, ev, es, eq);
    trade(32'd100, 32'd4, 64'h77, pv, gv, gs, gp, gq, gr);
    checks++; if (gv !== ev || gs !== es) begin errors++; $display("FAIL wrap_order got %0h/%0h exp %0h/%0h", gv, gs, ev, es); end
  endtask

  task automatic test_backpressure();
    logic ev, es;
    logic [31:0] eq, sp, sq;
    logic sv;
    logic [63:0] sr;
    out_ready = 1'b0;
    model_step(32'd20, 32'd9, ev, es, eq);
    fire(8'h54, 32'd20, 32'd9, 64'hBEEF);
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== ev) begin errors++; $display("FAIL bp_valid got %0h exp %0h", out_valid, ev); end
    sv = out_side; sp = out_price; sq = out_qty; sr = out_ref_id;
    fire(8'h54, $urandom_range(1, 500), 32'd1, 64'h1);
    fire(8'h54, $urandom_range(1, 500), 32'd1, 64'h2);
    fire(8'h41, 32'd3, 32'd3, 64'h3);
    exp_drops += 2;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %0h exp 1", out_valid); end
    checks++; if (out_side !== 1'b1 || out_price !== 32'd20 || out_qty !== eq || out_ref_id !== 64'hBEEF)
      begin errors++; $display("FAIL bp_stable got %0h/%0d/%0d/%0h exp 1/20/%0d/beef", out_side, out_price, out_qty, out_ref_id, eq); end
    checks++; if (out_side !== sv || out_price !== sp || out_qty !== sq || out_ref_id !== sr)
      begin errors++; $display("FAIL bp_unchanged got %0d exp %0d", out_price, sp); end
    checks++; if (drop_count !== 16'(exp_drops)) begin errors++; $display("FAIL bp_drops got %0d exp %0d", drop_count, exp_drops); end
    @(negedge clk);
    out_ready = 1'b1;
    msg_type = 8'h54; price = 32'd1; field_valid = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; field_valid = 1'b0;
    exp_drops += 1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake got %0h exp 0", out_valid); end
    checks++; if (drop_count !== 16'(exp_drops)) begin errors++; $display("FAIL bp_hs_drop got %0d exp %0d", drop_count, exp_drops); end
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_single got %0h exp 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_filter_cap();
    logic pv, gv, gs, ev, es;
    logic [31:0] gp, gq, eq;
    logic [63:0] gr;
    fire(8'h41, 32'd0, 32'd0, 64'h0);
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL filter_valid got %0h exp 0", out_valid); end
    checks++; if (drop_count !== 16'(exp_drops)) begin errors++; $display("FAIL filter_drop got %0d exp %0d", drop_count, exp_drops); end
    model_step(32'd10, 32'd5000, ev, es, eq);
    trade(32'd10, 32'd5000, 64'hCA9, pv, gv, gs, gp, gq, gr);
    checks++; if (gv !== ev || gs !== es) begin errors++; $display("FAIL cap_order got %0h/%0h exp %0h/%0h", gv, gs, ev, es); end
    checks++; if (gq !== 32'd1000 || eq !== 32'd1000) begin errors++; $display("FAIL cap_qty got %0d exp 1000", gq); end
  endtask

  task automatic test_random();
    logic pv, gv, gs, ev, es;
    logic [31:0] gp, gq, eq, p, v;
    logic [63:0] gr, id;
    for (int i = 0; i < 40; i++) begin
      p  = $urandom_range(40, 160);
      v  = $urandom_range(0, 2000);
      id = {$urandom, $urandom};
      model_step(p, v, ev, es, eq);
      trade(p, v, id, pv, gv, gs, gp, gq, gr);
      checks++;
      if (pv !== 1'b0 || gv !== ev) begin
        errors++; $display("FAIL rand_valid[%0d] got %0h exp %0h", i, gv, ev);
      end else if (ev && (gs !== es || gp !== p || gq !== eq || gr !== id)) begin
        errors++; $display("FAIL rand_fields[%0d] got %0h/%0d/%0d/%0h exp %0h/%0d/%0d/%0h",
                           i, gs, gp, gq, gr, es, p, eq, id);
      end
    end
    checks++; if (warm !== 1'b1) begin errors++; $display("FAIL rand_warm got %0h exp 1", warm); end
  endtask

  task automatic test_reset_mid();
    logic pv, gv, gs, ev, es;
    logic [31:0] gp, gq, eq;
    logic [63:0] gr;
    out_ready = 1'b0;
    model_step(32'd1, 32'd2, ev, es, eq);
    fire(8'h54, 32'd1, 32'd2, 64'h99);
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== ev) begin errors++; $display("FAIL rmid_pre got %0h exp %0h", out_valid, ev); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || warm !== 1'b0 || drop_count !== 16'd0)
      begin errors++; $display("FAIL rmid_async got %0h/%0h/%0d exp 0/0/0", out_valid, warm, drop_count); end
    win_q.delete();
    exp_drops = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      model_step(32'd500 - 32'(i * 60), 32'd1, ev, es, eq);
      trade(32'd500 - 32'(i * 60), 32'd1, 64'(i), pv, gv, gs, gp, gq, gr);
      checks++; if (gv !== ev) begin errors++; $display("FAIL rmid_cold[%0d] got %0h exp %0h", i, gv, ev); end
    end
    checks++; if (warm !== 1'b0) begin errors++; $display("FAIL rmid_warm got %0h exp 0", warm); end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_buy();
    test_sell_wrap();
    test_backpressure();
    test_filter_cap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
